// File: rtl/fb_pkg.sv
// Shared game-state encoding and scroll defaults for the flappy playfield blocks.
// Latency: n/a (types, constants and helpers only).
// Backpressure: n/a.
package fb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DYING = 2'd2,
    ST_OVER  = 2'd3
  } state_e;

  localparam int SPEED_DEF      = 2;
  localparam int PIPE_START_DEF = 639;

  // Score counter increment that sticks at its maximum instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector for a level input synchronous to clk.
// Latency: rise is combinational from d against a one-cycle history register.
// Backpressure: none; d is sampled every cycle.
module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic d_q, d_d;
  logic armed_q, armed_d;

  // History follows the input; armed goes high one cycle after reset so a
  // level already held high across reset release is not mistaken for a press.
  always_comb begin
    d_d     = d;
    armed_d = 1'b1;
  end

  // History and arm flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q     <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      d_q     <= d_d;
      armed_q <= armed_d;
    end
  end

  assign rise = d & ~d_q & armed_q;

endmodule

// File: rtl/scroll_ctrl.sv
// Game-state FSM driving background scroll, grass phase, pipe position and score.
// Latency: one cycle from a sampled input to every registered output.
// Backpressure: none; frame_tick, flap and collide are sampled every cycle.
module scroll_ctrl
  import fb_pkg::*;
#(
  parameter int SPEED        = SPEED_DEF,
  parameter int PIPE_START   = PIPE_START_DEF,
  parameter int DYING_FRAMES = 32,
  parameter int OVER_HOLD    = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       flap,
  input  logic       collide,
  output logic       scroll_en,
  output logic [3:0] grass_pos,
  output logic [9:0] pipe_x,
  output logic [7:0] score,
  output logic [1:0] state
);

  localparam int CNT_MAX = (DYING_FRAMES > OVER_HOLD) ? DYING_FRAMES : OVER_HOLD;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] DYING_LAST = CNT_W'(DYING_FRAMES - 1);
  localparam logic [CNT_W-1:0] OVER_HOLD_C = CNT_W'(OVER_HOLD);
  localparam logic [9:0]       SPEED_X    = 10'(SPEED);
  localparam logic [3:0]       SPEED_G    = 4'(SPEED);
  localparam logic [9:0]       PIPE_RLD   = 10'(PIPE_START);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       grass_q, grass_d;
  logic [9:0]       pipe_q, pipe_d;
  logic [7:0]       score_q, score_d;
  logic             scroll_q, scroll_d;
  logic             flap_rise;

  rise_detect u_flap_rise (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (flap),
    .rise  (flap_rise)
  );

  // Next-state and datapath: counter cleared on every state entry; playfield
  // only advances on a tick in RUN that is not also a collision.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    grass_d = grass_q;
    pipe_d  = pipe_q;
    score_d = score_q;
    case (state_q)
      ST_IDLE: begin
        if (flap_rise) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        if (collide) begin
          state_d = ST_DYING;
          cnt_d   = '0;
        end else if (frame_tick) begin
          grass_d = grass_q + SPEED_G;
          if (pipe_q > SPEED_X) begin
            pipe_d = pipe_q - SPEED_X;
          end else begin
            pipe_d  = PIPE_RLD;
            score_d = sat_inc8(score_q);
          end
        end
      end
      ST_DYING: begin
        if (frame_tick) begin
          if (cnt_q == DYING_LAST) begin
            state_d = ST_OVER;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_OVER: begin
        // Presses before the hold period has elapsed are dropped.
        if (flap_rise && (cnt_q >= OVER_HOLD_C)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          pipe_d  = PIPE_RLD;
          score_d = 8'd0;
        end else if (frame_tick && (cnt_q < OVER_HOLD_C)) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    // Derived from the next state so scroll_en changes on the same edge as state.
    scroll_d = (state_d == ST_RUN);
  end

  // All game state and outputs are registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      grass_q  <= 4'd0;
      pipe_q   <= PIPE_RLD;
      score_q  <= 8'd0;
      scroll_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      grass_q  <= grass_d;
      pipe_q   <= pipe_d;
      score_q  <= score_d;
      scroll_q <= scroll_d;
    end
  end

  assign scroll_en = scroll_q;
  assign grass_pos = grass_q;
  assign pipe_x    = pipe_q;
  assign score     = score_q;
  assign state     = state_q;

endmodule
